// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: width codes, FSM states, port ids
// and the latched request payload.
package mem_bus_pkg;

    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    localparam logic P_CPU = 1'b0;
    localparam logic P_DMA = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    // One requester's access as captured at grant time.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic        we;
    } bus_req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between CPU and DMA.
//   c_req/d_req, c_lock/d_lock : requests and ownership-hold flags
//   prev_owner                 : last granted port (P_CPU/P_DMA)
//   mode                       : 0 fixed priority (DMA wins), 1 round-robin
//   grant_valid / grant_id     : someone requests / which port wins
module mem_arb_pick
    import mem_bus_pkg::*;
(
    input  logic c_req,
    input  logic d_req,
    input  logic c_lock,
    input  logic d_lock,
    input  logic prev_owner,
    input  logic mode,
    output logic grant_valid,
    output logic grant_id
);

    // A locked previous owner keeps the bus; ties resolved by mode.
    always_comb begin
        grant_valid = c_req | d_req;
        grant_id    = P_CPU;
        if ((prev_owner == P_DMA) && d_req && d_lock) begin
            grant_id = P_DMA;
        end else if ((prev_owner == P_CPU) && c_req && c_lock) begin
            grant_id = P_CPU;
        end else if (c_req && d_req) begin
            grant_id = mode ? ~prev_owner : P_DMA;
        end else if (d_req) begin
            grant_id = P_DMA;
        end else begin
            grant_id = P_CPU;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the system memory bus between the CPU (c_*) and DMA (d_*) ports.
// One request is latched at a time and held on the bus for the whole access,
// including RD_LAT cycles of synchronous read latency; completion is a
// one-cycle ack (with rdata/err) to the owning port.
//   c_*/d_*      : requester ports (req held until ack)
//   mem_*        : bus side; mem_data_oe mirrors mem_write
//   busy, owner  : state != IDLE, last granted port (0 CPU, 1 DMA)
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_req,
    input  logic        c_lock,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [1:0]  c_width,
    input  logic        c_we,
    output logic        c_ack,
    output logic        c_err,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_lock,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_width,
    input  logic        d_we,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_data_oe,
    output logic [1:0]  mem_width,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ok,
    output logic        busy,
    output logic        owner
);

    localparam int unsigned CW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] RD_TARGET = CW'(RD_LAT);
    localparam logic [TW-1:0] T_LAST    = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic          ARB_RR    = (ARB_MODE != 0);

    arb_state_t  state_q, state_d;
    bus_req_t    req_q, req_d, c_in, d_in;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic        owner_q, owner_d;
    logic        c_ack_q, c_ack_d, d_ack_q, d_ack_d;
    logic        c_err_q, c_err_d, d_err_q, d_err_d;
    logic [31:0] c_rdata_q, c_rdata_d, d_rdata_q, d_rdata_d;
    logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic        busy_q, busy_d;
    logic        grant_valid, grant_id;
    logic        fin, fin_err;
    logic [31:0] fin_rdata;

    assign c_in = '{addr: c_addr, wdata: c_wdata, width: c_width, we: c_we};
    assign d_in = '{addr: d_addr, wdata: d_wdata, width: d_width, we: d_we};

    mem_arb_pick u_pick (
        .c_req      (c_req),
        .d_req      (d_req),
        .c_lock     (c_lock),
        .d_lock     (d_lock),
        .prev_owner (owner_q),
        .mode       (ARB_RR),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        owner_d     = owner_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        fin         = 1'b0;
        fin_err     = 1'b0;
        fin_rdata   = '0;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    req_d       = (grant_id == P_DMA) ? d_in : c_in;
                    owner_d     = grant_id;
                    cnt_d       = '0;
                    tcnt_d      = '0;
                    state_d     = BUSY;
                    mem_read_d  = ~req_d.we;
                    mem_write_d = req_d.we;
                end
            end
            BUSY: begin
                mem_read_d  = ~req_q.we;
                mem_write_d = req_q.we;
                if (mem_ok) begin
                    tcnt_d = '0;
                    // Reads wait RD_LAT ready cycles for the RAM q to settle.
                    if (cnt_q == (req_q.we ? '0 : RD_TARGET)) begin
                        fin       = 1'b1;
                        fin_rdata = req_q.we ? 32'h0 : mem_rdata;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                    if ((TIMEOUT != 0) && (tcnt_q == T_LAST)) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                end
                if (fin) begin
                    state_d     = ACK;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        c_ack_d   = fin && (owner_q == P_CPU);
        d_ack_d   = fin && (owner_q == P_DMA);
        c_err_d   = c_ack_d && fin_err;
        d_err_d   = d_ack_d && fin_err;
        c_rdata_d = c_ack_d ? fin_rdata : 32'h0;
        d_rdata_d = d_ack_d ? fin_rdata : 32'h0;
        busy_d    = (state_d != IDLE);
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            owner_q     <= P_CPU;
            c_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            c_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            owner_q     <= owner_d;
            c_ack_q     <= c_ack_d;
            d_ack_q     <= d_ack_d;
            c_err_q     <= c_err_d;
            d_err_q     <= d_err_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
        end
    end

    assign c_ack       = c_ack_q;
    assign d_ack       = d_ack_q;
    assign c_err       = c_err_q;
    assign d_err       = d_err_q;
    assign c_rdata     = c_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_addr    = req_q.addr;
    assign mem_wdata   = req_q.wdata;
    assign mem_width   = req_q.width;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_data_oe = mem_write_q;
    assign busy        = busy_q;
    assign owner       = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: two arbiters (fixed priority "a", round-robin "b") share
// one stimulus; cycle 0 is the cycle in which a request is raised.
module tb_mem_bus_arbiter;

    logic        clk, rst_n;
    logic        c_req, c_lock, c_we, d_req, d_lock, d_we, mem_ok;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata, mem_rdata;
    logic [1:0]  c_width, d_width;

    logic        a_c_ack, a_c_err, a_d_ack, a_d_err, a_oe, a_rd, a_wr, a_busy, a_owner;
    logic [31:0] a_c_rdata, a_d_rdata, a_addr, a_wdata;
    logic [1:0]  a_width;
    logic        b_c_ack, b_c_err, b_d_ack, b_d_err, b_oe, b_rd, b_wr, b_busy, b_owner;
    logic [31:0] b_c_rdata, b_d_rdata, b_addr, b_wdata;
    logic [1:0]  b_width;

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter #(.RD_LAT(1), .ARB_MODE(0), .TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_width(c_width), .c_we(c_we), .c_ack(a_c_ack), .c_err(a_c_err), .c_rdata(a_c_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_we(d_we), .d_ack(a_d_ack), .d_err(a_d_err), .d_rdata(a_d_rdata),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_data_oe(a_oe), .mem_width(a_width),
        .mem_read(a_rd), .mem_write(a_wr), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
        .busy(a_busy), .owner(a_owner)
    );

    mem_bus_arbiter #(.RD_LAT(1), .ARB_MODE(1), .TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_width(c_width), .c_we(c_we), .c_ack(b_c_ack), .c_err(b_c_err), .c_rdata(b_c_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_width(d_width), .d_we(d_we), .d_ack(b_d_ack), .d_err(b_d_err), .d_rdata(b_d_rdata),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_data_oe(b_oe), .mem_width(b_width),
        .mem_read(b_rd), .mem_write(b_wr), .mem_rdata(mem_rdata), .mem_ok(mem_ok),
        .busy(b_busy), .owner(b_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        c_req = 0; c_lock = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_width = 0;
        d_req = 0; d_lock = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_width = 0;
        mem_ok = 1; mem_rdata = 0;
        rst_n = 0;
        #23;
        @(negedge clk) rst_n = 1;
        step();
    endtask

    int dack, bdack, wr, cack_cyc;

    initial begin
        do_reset();
        check("rst_c_ack", 32'(a_c_ack), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_owner", 32'(a_owner), 0);
        check("rst_rw", 32'({a_rd, a_wr, a_oe}), 0);

        // 1: CPU word read, RD_LAT=1
        c_req = 1; c_we = 0; c_addr = 32'h0300_0010; c_width = 2'd2; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("t1_rd_c1", 32'(a_rd), 1);
        check("t1_addr_c1", a_addr, 32'h0300_0010);
        check("t1_width", 32'(a_width), 2);
        check("t1_busy", 32'(a_busy), 1);
        c_addr = 32'h1111_1111;
        step();
        check("t1_rd_c2", 32'(a_rd), 1);
        check("t1_addr_held", a_addr, 32'h0300_0010);
        check("t1_noack_c2", 32'(a_c_ack), 0);
        step();
        check("t1_c_ack", 32'(a_c_ack), 1);
        check("t1_c_rdata", a_c_rdata, 32'hDEAD_BEEF);
        check("t1_c_err", 32'(a_c_err), 0);
        check("t1_d_ack", 32'({a_d_ack, a_d_rdata}), 0);
        check("t1_rd_off", 32'(a_rd), 0);
        check("t1_b_c_ack", 32'(b_c_ack), 1);
        c_req = 0;
        step();
        check("t1_ack_pulse", 32'(a_c_ack), 0);
        check("t1_idle", 32'(a_busy), 0);

        // 2: simultaneous requests, prev owner CPU -> DMA wins in both modes
        c_req = 1; c_we = 0; c_addr = 32'h0000_0100; mem_rdata = 32'h1234_5678;
        d_req = 1; d_we = 1; d_addr = 32'h0000_0200; d_wdata = 32'h0000_55AA; d_width = 2'd1;
        step();
        check("t2_owner_a", 32'(a_owner), 1);
        check("t2_owner_b", 32'(b_owner), 1);
        check("t2_wr", 32'({a_wr, a_oe, a_rd}), 32'b110);
        check("t2_addr", a_addr, 32'h0000_0200);
        check("t2_wdata", a_wdata, 32'h0000_55AA);
        step();
        check("t2_d_ack", 32'({a_d_ack, a_c_ack, b_d_ack}), 32'b101);
        check("t2_d_rdata", a_d_rdata, 0);
        d_req = 0;
        step();
        check("t2_idle", 32'(a_busy), 0);
        step();
        check("t2_cpu_owner", 32'(a_owner), 0);
        check("t2_cpu_addr", a_addr, 32'h0000_0100);
        step();
        step();
        check("t2_c_ack", 32'(a_c_ack), 1);
        check("t2_c_rdata", a_c_rdata, 32'h1234_5678);
        c_req = 0;
        step();
        // 2b: DMA-only access, then a tie with prev owner DMA
        d_req = 1; d_we = 1; d_addr = 32'h0000_0300;
        step();
        step();
        check("t2b_d_ack", 32'({a_d_ack, b_d_ack}), 32'b11);
        d_req = 0;
        step();
        c_req = 1; c_we = 0; c_addr = 32'h0000_0400;
        d_req = 1; d_addr = 32'h0000_0500;
        step();
        check("t2b_owner_fixed", 32'(a_owner), 1);
        check("t2b_owner_rr", 32'(b_owner), 0);
        check("t2b_rr_addr", b_addr, 32'h0000_0400);
        check("t2b_rr_read", 32'({b_rd, b_wr}), 32'b10);

        // 3: DMA locked burst of three word writes with CPU waiting
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h0300_0020; mem_rdata = 32'h0BAD_F00D;
        d_req = 1; d_lock = 1; d_we = 1; d_width = 2'd2; d_addr = 32'h0600_0000; d_wdata = 32'hA0;
        dack = 0; bdack = 0; wr = 0; cack_cyc = -1;
        for (int i = 1; i <= 30 && cack_cyc < 0; i++) begin
            step();
            if (a_wr) begin
                check("t3_wr_addr", a_addr, 32'h0600_0000 + 32'(4 * wr));
                wr++;
            end
            if (b_d_ack) bdack++;
            if (a_d_ack) begin
                dack++;
                if (dack == 3) begin
                    d_req = 0; d_lock = 0;
                end else begin
                    d_addr = d_addr + 32'd4;
                end
            end
            if (a_c_ack) begin
                cack_cyc = i;
                check("t3_cack_after_unlock", 32'(dack), 3);
                check("t3_c_rdata", a_c_rdata, 32'h0BAD_F00D);
                c_req = 0;
            end
        end
        check("t3_cack_cycle", 32'(cack_cyc), 12);
        check("t3_d_acks", 32'(dack), 3);
        check("t3_d_acks_rr", 32'(bdack), 3);
        check("t3_wr_cycles", 32'(wr), 3);
        step();

        // 4: write stalled by four mem_ok-low cycles
        c_req = 1; c_we = 1; c_addr = 32'h0200_0040; c_wdata = 32'hCAFE_F00D; mem_ok = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("t4_wr_held", 32'({a_wr, a_c_ack}), 32'b10);
            check("t4_addr_held", a_addr, 32'h0200_0040);
        end
        step();
        mem_ok = 1;
        check("t4_wr_c5", 32'({a_wr, a_c_ack}), 32'b10);
        step();
        check("t4_c_ack", 32'({a_c_ack, a_c_err, a_wr}), 32'b100);
        c_req = 0;
        step();

        // 5: timeout abort with mem_ok stuck low
        c_req = 1; c_we = 0; c_addr = 32'h0000_0010; mem_ok = 0; mem_rdata = 32'hFFFF_0000;
        cack_cyc = -1;
        for (int i = 1; i <= 20 && cack_cyc < 0; i++) begin
            step();
            if (a_c_ack) begin
                cack_cyc = i;
                check("t5_c_err", 32'(a_c_err), 1);
                check("t5_c_rdata", a_c_rdata, 0);
                c_req = 0;
            end
        end
        check("t5_ack_cycle", 32'(cack_cyc), 9);
        step();
        check("t5_idle", 32'(a_busy), 0);
        mem_ok = 1;

        // 6: async reset in the middle of a DMA read
        d_req = 1; d_we = 0; d_addr = 32'h0000_0080; mem_ok = 0;
        step();
        step();
        check("t6_busy_pre", 32'({a_busy, a_owner, a_rd}), 32'b111);
        #3;
        rst_n = 0;
        #1;
        check("t6_rst_busy", 32'({a_busy, a_owner, a_rd, a_wr, b_busy}), 0);
        check("t6_rst_addr", a_addr, 0);
        check("t6_rst_ack", 32'({a_d_ack, a_c_ack}), 0);
        d_req = 0; mem_ok = 1;
        @(negedge clk) rst_n = 1;
        step();
        c_req = 1; c_we = 0; c_addr = 32'h0300_0010; mem_rdata = 32'hA5A5_A5A5;
        step();
        check("t6_no_stale_ack", 32'(a_d_ack), 0);
        step();
        step();
        check("t6_c_ack", 32'(a_c_ack), 1);
        check("t6_c_rdata", a_c_rdata, 32'hA5A5_A5A5);
        c_req = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single system memory bus (BIOS ROM, internal RAM, pak RAM, VRAM write path) between two requesters: CPU (port c) and DMA engine (port d).
- Latches one request at a time and drives the bus for the full access, including the synchronous-RAM read latency.
- Returns read data with a one-cycle ack pulse.
- Sits between the core/DMA and the memory block; the top level joins mem_wdata/mem_data_oe onto the bidirectional data bus.

Parameters:
- RD_LAT, 1, cycles from the first mem_read cycle until memory read data is valid (synchronous RAM q).
- ARB_MODE, 0, 0 = fixed priority (DMA wins), 1 = round-robin.
- TIMEOUT, 255, maximum consecutive mem_ok-low cycles in BUSY before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- c_req  in  1  CPU request; held until c_ack
- c_lock  in  1  CPU keeps ownership for the next access
- c_addr  in  32  CPU byte address
- c_wdata  in  32  CPU write data
- c_width  in  2  access width: 0 byte, 1 half, 2 word
- c_we  in  1  1 = write, 0 = read
- c_ack  out  1  one-cycle completion pulse
- c_err  out  1  valid with c_ack; timeout abort
- c_rdata  out  32  valid with c_ack on reads
- d_req, d_lock, d_addr, d_wdata, d_width, d_we  in  1/1/32/32/2/1  DMA port, same meaning as CPU port
- d_ack, d_err, d_rdata  out  1/1/32  DMA port, same meaning as CPU port
- mem_addr  out  32  bus address
- mem_wdata  out  32  bus write data
- mem_data_oe  out  1  drive data bus (equals mem_write)
- mem_width  out  2  bus width
- mem_read  out  1  bus read strobe
- mem_write  out  1  bus write strobe
- mem_rdata  in  32  bus read data
- mem_ok  in  1  memory ready
- busy  out  1  state is not IDLE
- owner  out  1  0 = CPU, 1 = DMA; last granted port

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE; cnt and tcnt cleared.
  - All outputs 0; owner resets to 0.
  - An in-flight transaction is dropped with no ack.
- States:
  - IDLE: no request pending.
  - BUSY: access in progress on the bus.
  - ACK: completion pulse to the owner.
- IDLE:
  - On an edge with any req high, pick the winner and latch its addr/wdata/width/we into the internal registers.
  - Set owner to the winner, clear cnt and tcnt, go to BUSY.
  - With no req, stay in IDLE.
- Pick rules, in order:
  - (a) If the previous owner has req and lock both high, it wins.
  - (b) ARB_MODE=0: DMA wins any tie.
  - (c) ARB_MODE=1: the port that is not the previous owner wins a tie.
  - (d) Otherwise the sole requester wins.
- BUSY:
  - mem_addr, mem_width and mem_wdata come from the latched registers.
  - mem_read = !we and mem_write = we; both are 0 outside BUSY.
  - Each edge with mem_ok=1:
    - if cnt == target (RD_LAT for reads, 0 for writes), capture mem_rdata (writes capture 0) and go to ACK;
    - otherwise cnt++.
    - tcnt clears.
  - Each edge with mem_ok=0:
    - cnt holds and tcnt++.
    - If TIMEOUT != 0 and tcnt == TIMEOUT-1, go to ACK with err=1 and rdata=0.
- ACK:
  - The owner's ack is 1 for exactly one cycle, with rdata/err valid; the other port's ack, rdata and err stay 0.
  - Next edge goes to IDLE.
  - A req still high during ACK is evaluated as a new request in IDLE.
- Latency with mem_ok=1 and req high in cycle 0:
  - read: ack in cycle 2+RD_LAT;
  - write: ack in cycle 2.
  - Minimum request-to-request spacing is 3 cycles.
- Requester signals change after accept without effect; the latched copy is used.
- Width and addr pass through unmodified; byte shifting is done in memory.
- cnt is sized by $clog2(RD_LAT+1) and tcnt by $clog2(TIMEOUT+1), with a minimum of 1 bit each.

Decomposition:
- Package mem_bus_pkg holds:
  - width encodings (W_BYTE=0, W_HALF=1, W_WORD=2);
  - the state enum (IDLE, BUSY, ACK);
  - port ids (P_CPU=0, P_DMA=1).
- One sub-module, mem_arb_pick, is purely combinational:
  - inputs c_req, d_req, c_lock, d_lock, prev_owner, mode;
  - outputs grant_valid and grant_id.

Test Plan:
1. Reset, then CPU read of 0x0300_0010 (width 2, RD_LAT=1, mem_rdata=0xDEADBEEF): mem_read high in cycles 1-2, c_ack in cycle 3 with c_rdata=0xDEADBEEF, c_err=0, d_ack=0.
2. c_req and d_req rise in the same cycle, ARB_MODE=0: DMA is served first (owner=1), CPU is granted in the IDLE that follows the DMA ack. With ARB_MODE=1 and prev owner=DMA, CPU wins the tie.
3. DMA holds d_lock=1 and d_req=1 for 3 word writes to 0x0600_0000/4/8 while c_req is high: three d_acks, c_ack only after d_lock drops, mem_write high exactly 3 cycles total.
4. mem_ok held low for 4 cycles during a CPU write: the ack is delayed by 4 cycles, mem_write stays high and mem_addr stays stable throughout.
5. TIMEOUT=8, mem_ok stuck at 0: c_ack with c_err=1 and c_rdata=0 eight cycles after entering BUSY, then IDLE.
6. rst_n asserted low in the middle of BUSY: all outputs 0 immediately (asynchronously), no ack. After release, the next request is served normally.
